// File: rtl/bsg_counter_load_down_saturating.sv
// Loadable down counter that saturates at zero, for credit/timeout countdowns.
// Emits a one-cycle expire pulse when a decrement reaches zero, with optional auto-reload.
//
//  state  | meaning
//  -------+-------------------------------------------------------------
//  IDLE   | count is zero, nothing pending
//  RUN    | count is non-zero
//  EXPIRE | one cycle after a decrement reached zero; drives expire_o
module bsg_counter_load_down_saturating #(
   parameter int max_val_p    = 1,
   parameter int init_val_p   = 0,
   parameter int reload_en_p  = 0,
   parameter int ptr_width_lp = (max_val_p < 1) ? 1 : $clog2(max_val_p + 1)
) (
   input  logic                    clk_i,
   input  logic                    reset_n_i,
   input  logic                    load_i,
   input  logic [ptr_width_lp-1:0] load_val_i,
   input  logic                    down_i,
   output logic [ptr_width_lp-1:0] count_r_o,
   output logic                    zero_o,
   output logic                    expire_o,
   output logic                    underflow_r_o
);

   localparam logic [ptr_width_lp-1:0] max_lp  = ptr_width_lp'(max_val_p);
   localparam logic [ptr_width_lp-1:0] init_lp = ptr_width_lp'(init_val_p);
   localparam logic [ptr_width_lp-1:0] one_lp  = ptr_width_lp'(1);

   typedef enum logic [1:0] {
      idle_s   = 2'd0,
      run_s    = 2'd1,
      expire_s = 2'd2
   } state_e;

   state_e                  state_r, state_n;
   logic [ptr_width_lp-1:0] reload_r, reload_n;
   logic [ptr_width_lp-1:0] count_n;
   logic                    underflow_n;
   logic [ptr_width_lp-1:0] lv;
   logic                    hit_zero;

   assign lv = (load_val_i > max_lp) ? max_lp : load_val_i;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_r       <= (init_val_p == 0) ? idle_s : run_s;
         count_r_o     <= init_lp;
         reload_r      <= init_lp;
         underflow_r_o <= 1'b0;
      end else begin
         state_r       <= state_n;
         count_r_o     <= count_n;
         reload_r      <= reload_n;
         underflow_r_o <= underflow_n;
      end
   end

   // Load is applied before the decrement, so load+down counts from the clamped value.
   always_comb begin
      count_n     = count_r_o;
      reload_n    = reload_r;
      underflow_n = underflow_r_o;
      hit_zero    = 1'b0;
      if (load_i) begin
         reload_n    = lv;
         underflow_n = 1'b0;
         if (!down_i)
            count_n = lv;
         else if (lv == '0)
            count_n = '0;
         else if (lv == one_lp)
            hit_zero = 1'b1;
         else
            count_n = lv - one_lp;
      end else if (down_i) begin
         if (count_r_o > one_lp)
            count_n = count_r_o - one_lp;
         else if (count_r_o == one_lp)
            hit_zero = 1'b1;
         else
            underflow_n = 1'b1;
      end
      // Reload uses the freshly loaded value when load and the final decrement coincide.
      if (hit_zero)
         count_n = (reload_en_p != 0) ? reload_n : '0;

      if (hit_zero)
         state_n = expire_s;
      else if (count_n == '0)
         state_n = idle_s;
      else
         state_n = run_s;
   end

   always_comb begin
      expire_o = (state_r == expire_s);
      zero_o   = (count_r_o == '0);
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk_i) begin
      if (reset_n_i) begin
         assert (init_val_p <= max_val_p)
            else $error("init_val_p exceeds max_val_p");
         assert (count_r_o <= max_lp)
            else $error("count exceeds max_val_p");
      end
   end
`endif

endmodule
